// File: rtl/line_buffer_3row.sv
// line_buffer_3row: two line RAMs delaying a raster pixel stream so that each
// accepted pixel comes out with the pixels one and two lines above it, in the
// same column, one cycle later.
//
// state | meaning
// IDLE  | after reset, waiting for the first sof
// FILL  | rows 0 and 1 being stored, no output triples yet
// RUN   | rows 2..PIC_HEIGHT-1, every accepted pixel yields a triple
// DONE  | last pixel taken, waiting for the next sof
module line_buffer_3row #(
  parameter int WIDTH      = 24,
  parameter int PIC_WIDTH  = 480,
  parameter int PIC_HEIGHT = 272,
  parameter int ADDR_W     = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             frame_done,
  output logic             err_overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(PIC_WIDTH - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(PIC_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ROW_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ROW_TWO  = ADDR_W'(2);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] col, row;
  logic [ADDR_W-1:0] col_cur, row_cur;
  logic [ADDR_W-1:0] col_nxt, row_nxt;
  logic              in_frame;
  logic              accept;
  logic              col_last;
  logic              last_pix;
  logic              emit;
  logic [WIDTH-1:0]  rd_a, rd_b;

  // ram_a holds the previous line, ram_b the line before that
  logic [WIDTH-1:0]  ram_a [0:PIC_WIDTH-1];
  logic [WIDTH-1:0]  ram_b [0:PIC_WIDTH-1];

  // State and position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end

  // Next-state, counter advance and accept decode; sof restarts the position
  // in the same cycle so a pixel arriving with sof lands at (0,0)
  always_comb begin
    col_cur   = sof ? '0 : col;
    row_cur   = sof ? '0 : row;
    in_frame  = sof || (state == FILL) || (state == RUN);
    accept    = valid_in && in_frame;
    col_last  = (col_cur == COL_LAST);
    last_pix  = accept && col_last && (row_cur == ROW_LAST);
    emit      = accept && (row_cur >= ROW_TWO);
    state_nxt = state;
    col_nxt   = col_cur;
    row_nxt   = row_cur;
    if (sof) begin
      state_nxt = FILL;
    end
    if (accept) begin
      if (col_last) begin
        col_nxt = '0;
        row_nxt = (row_cur == ROW_LAST) ? '0 : row_cur + ROW_ONE;
      end else begin
        col_nxt = col_cur + ROW_ONE;
      end
      if (last_pix) begin
        state_nxt = DONE;
      end else if (col_last && (row_cur == ROW_ONE)) begin
        state_nxt = RUN;
      end
    end
  end

  // Combinational read of both lines at the current column
  always_comb begin
    rd_a = ram_a[col_cur];
    rd_b = ram_b[col_cur];
  end

  // Line RAM shift: old A moves to B, new pixel into A; contents survive reset
  always_ff @(posedge clk) begin
    if (accept) begin
      ram_b[col_cur] <= rd_a;
      ram_a[col_cur] <= din;
    end
  end

  // Registered outputs; data holds whenever no triple is produced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      dout1      <= '0;
      dout2      <= '0;
      dout3      <= '0;
    end else begin
      valid_out  <= emit;
      frame_done <= last_pix;
      if (emit) begin
        dout1 <= rd_b;
        dout2 <= rd_a;
        dout3 <= din;
      end
    end
  end

  // Sticky overrun flag: a pixel offered while no frame is open
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overrun <= 1'b0;
    end else if (sof) begin
      err_overrun <= 1'b0;
    end else if (valid_in && !in_frame) begin
      err_overrun <= 1'b1;
    end
  end

endmodule
